// File: rtl/mem_arb_pkg.sv
// Shared encodings for the I/D memory port arbiter: FSM states, grant IDs
// and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for an outstanding memory request; expired is raised
// combinationally once the count reaches TIMEOUT-1. No backpressure.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one memory port between fetch (I) and load/store (D).
// Latency: grant +1, ack +1 after m_ack; requesters hold req until ack, watchdog aborts stuck requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int             AW        = 32,
  parameter int             DW        = 32,
  parameter int             TIMEOUT   = 255,
  parameter logic [DW-1:0]  ERR_RDATA = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [3:0]    m_be,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          grant_d,
  output logic          busy
);

  state_t        state, state_n;
  logic          last_grant, last_grant_n;
  logic          m_req_n, m_we_n;
  logic [AW-1:0] m_addr_n;
  logic [DW-1:0] m_wdata_n;
  logic [3:0]    m_be_n;
  logic [DW-1:0] i_rdata_n, d_rdata_n;
  logic          i_ack_n, i_err_n, d_ack_n, d_err_n;
  logic          pick_d;
  logic          tmr_clr, tmr_en, tmr_expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // D wins when it is the only requester or when I was served last.
  assign pick_d = d_req && (!i_req || (last_grant == GNT_I));

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    m_req_n      = m_req;
    m_we_n       = m_we;
    m_addr_n     = m_addr;
    m_wdata_n    = m_wdata;
    m_be_n       = m_be;
    i_rdata_n    = i_rdata;
    d_rdata_n    = d_rdata;
    i_ack_n      = 1'b0;
    i_err_n      = 1'b0;
    d_ack_n      = 1'b0;
    d_err_n      = 1'b0;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_req || d_req) begin
          state_n = ST_BUSY;
          m_req_n = 1'b1;
          tmr_clr = 1'b1;
          if (pick_d) begin
            last_grant_n = GNT_D;
            m_we_n       = d_we;
            m_addr_n     = d_addr;
            m_wdata_n    = d_wdata;
            m_be_n       = d_we ? d_be : BE_ALL;
          end else begin
            last_grant_n = GNT_I;
            m_we_n       = 1'b0;
            m_addr_n     = i_addr;
            m_wdata_n    = '0;
            m_be_n       = BE_ALL;
          end
        end
      end

      ST_BUSY: begin
        tmr_en = 1'b1;
        // A real ack takes precedence over a watchdog abort in the same cycle.
        if (m_ack) begin
          state_n = ST_RESP;
          m_req_n = 1'b0;
          m_we_n  = 1'b0;
          if (last_grant == GNT_D) begin
            d_rdata_n = m_rdata;
            d_ack_n   = 1'b1;
          end else begin
            i_rdata_n = m_rdata;
            i_ack_n   = 1'b1;
          end
        end else if (tmr_expired) begin
          state_n = ST_RESP;
          m_req_n = 1'b0;
          if (last_grant == GNT_D) begin
            d_rdata_n = ERR_RDATA;
            d_ack_n   = 1'b1;
            d_err_n   = 1'b1;
          end else begin
            i_rdata_n = ERR_RDATA;
            i_ack_n   = 1'b1;
            i_err_n   = 1'b1;
          end
        end
      end

      ST_RESP: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= GNT_I;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      m_req      <= m_req_n;
      m_we       <= m_we_n;
      m_addr     <= m_addr_n;
      m_wdata    <= m_wdata_n;
      m_be       <= m_be_n;
      i_rdata    <= i_rdata_n;
      d_rdata    <= d_rdata_n;
      i_ack      <= i_ack_n;
      i_err      <= i_err_n;
      d_ack      <= d_ack_n;
      d_err      <= d_err_n;
    end
  end

  assign grant_d = last_grant;
  assign busy    = (state != ST_IDLE);

endmodule
